// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - CPU and host bus bundle for the data-memory controller
interface dmem_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) ();
    logic [ADDR_WIDTH-1:0] cpu_addr_i;
    logic [DATA_WIDTH-1:0] cpu_wdata_i;
    logic                  cpu_wen_i;
    logic                  cpu_hold_i;
    logic [DATA_WIDTH-1:0] cpu_rdata_o;

    logic                  host_req_i;
    logic                  host_wen_i;
    logic [ADDR_WIDTH-1:0] host_addr_i;
    logic [DATA_WIDTH-1:0] host_wdata_i;
    logic                  host_ack_o;
    logic [DATA_WIDTH-1:0] host_rdata_o;

    logic [CNT_WIDTH-1:0]  cpu_wr_cnt_o;

    modport master (
        output cpu_addr_i, cpu_wdata_i, cpu_wen_i, cpu_hold_i,
        output host_req_i, host_wen_i, host_addr_i, host_wdata_i,
        input  cpu_rdata_o, host_ack_o, host_rdata_o, cpu_wr_cnt_o
    );

    modport slave (
        input  cpu_addr_i, cpu_wdata_i, cpu_wen_i, cpu_hold_i,
        input  host_req_i, host_wen_i, host_addr_i, host_wdata_i,
        output cpu_rdata_o, host_ack_o, host_rdata_o, cpu_wr_cnt_o
    );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data memory shared by CPU and host handshake port; DMEM_WCNT_EN enables the CPU store counter
module dmem_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  cpu_we_eff;
    logic                  host_grant;
    logic                  host_ack;
    logic [DATA_WIDTH-1:0] host_rdata;

    assign cpu_we_eff = bus.cpu_wen_i & ~bus.cpu_hold_i;
    // A CPU store always wins the array; the host simply retries next edge.
    assign host_grant = rst_n & (state == S_IDLE) & bus.host_req_i & ~cpu_we_eff;

    assign bus.cpu_rdata_o  = mem[bus.cpu_addr_i];
    assign bus.host_ack_o   = host_ack;
    assign bus.host_rdata_o = host_rdata;

    always_ff @(posedge clk) begin
        if (cpu_we_eff) begin
            mem[bus.cpu_addr_i] <= bus.cpu_wdata_i;
        end else if (host_grant && bus.host_wen_i) begin
            mem[bus.host_addr_i] <= bus.host_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            host_ack   <= 1'b0;
            host_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host_grant) begin
                        if (!bus.host_wen_i) begin
                            host_rdata <= mem[bus.host_addr_i];
                        end
                        host_ack <= 1'b1;
                        state    <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!bus.host_req_i) begin
                        host_ack <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    host_ack <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_WCNT_EN
    logic [CNT_WIDTH-1:0] wr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
        end else if (cpu_we_eff && (wr_cnt != {CNT_WIDTH{1'b1}})) begin
            wr_cnt <= wr_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.cpu_wr_cnt_o = wr_cnt;
`else
    assign bus.cpu_wr_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl (CNT_WIDTH = 4)
module tb_dmem_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [63:0] model_mem [256];
    logic [3:0]  exp_cnt;
    logic [63:0] exp_q [$];

    dmem_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .CNT_WIDTH(4)) bus ();

    dmem_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic count_store;
`ifdef DMEM_WCNT_EN
        if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
`endif
    endtask

    task automatic check_cnt(input string name);
        checks++;
        if (bus.cpu_wr_cnt_o !== exp_cnt) begin
            failures++;
            $display("FAIL %s: cpu_wr_cnt_o=%0h expected=%0h", name, bus.cpu_wr_cnt_o, exp_cnt);
        end
    endtask

    task automatic host_txn(input logic wen, input logic [7:0] addr, input logic [63:0] wdata,
                            input int exp_lat, input string name);
        int lat;
        logic [63:0] exp_rd;
        lat = 0;
        bus.host_wen_i   = wen;
        bus.host_addr_i  = addr;
        bus.host_wdata_i = wdata;
        bus.host_req_i   = 1'b1;
        if (!wen) exp_q.push_back(model_mem[addr]);
        while (bus.host_ack_o !== 1'b1 && lat < 16) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s_latency: cycles=%0d expected=%0d", name, lat, exp_lat);
        end
        if (bus.host_ack_o === 1'b1 && wen) model_mem[addr] = wdata;
        if (!wen) begin
            exp_rd = exp_q.pop_front();
            checks++;
            if (bus.host_rdata_o !== exp_rd) begin
                failures++;
                $display("FAIL %s_rdata: got=%h expected=%h", name, bus.host_rdata_o, exp_rd);
            end
        end
        bus.host_req_i = 1'b0;
        tick();
        checks++;
        if (bus.host_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_ack_drop: ack=%b expected=0", name, bus.host_ack_o);
        end
    endtask

    task automatic test_reset;
        logic [63:0] exp_rd;
        rst_n = 1'b0;
        #2;
        checks += 3;
        if (bus.host_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack: got=%b expected=0", bus.host_ack_o); end
        if (bus.host_rdata_o !== 64'h0) begin failures++; $display("FAIL reset_rdata: got=%h expected=0", bus.host_rdata_o); end
        if (bus.cpu_wr_cnt_o !== 4'h0) begin failures++; $display("FAIL reset_cnt: got=%h expected=0", bus.cpu_wr_cnt_o); end
        @(posedge clk);
        #1 rst_n = 1'b1;

        bus.cpu_addr_i = 8'h30; bus.cpu_wdata_i = 64'h77; bus.cpu_wen_i = 1'b1;
        tick();
        bus.cpu_wen_i = 1'b0;
        model_mem[8'h30] = 64'h77;
        count_store();
        host_txn(1'b1, 8'h20, 64'h0123_4567_89AB_CDEF, 1, "reset_prewrite");

        bus.host_wen_i = 1'b0; bus.host_addr_i = 8'h20; bus.host_req_i = 1'b1;
        exp_q.push_back(model_mem[8'h20]);
        tick();
        checks++;
        if (bus.host_ack_o !== 1'b1) begin failures++; $display("FAIL reset_pre_ack: got=%b expected=1", bus.host_ack_o); end
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 4'h0;
        checks += 3;
        if (bus.host_ack_o !== 1'b0) begin failures++; $display("FAIL reset_mid_ack: got=%b expected=0", bus.host_ack_o); end
        if (bus.host_rdata_o !== 64'h0) begin failures++; $display("FAIL reset_mid_rdata: got=%h expected=0", bus.host_rdata_o); end
        if (bus.cpu_wr_cnt_o !== 4'h0) begin failures++; $display("FAIL reset_mid_cnt: got=%h expected=0", bus.cpu_wr_cnt_o); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        exp_rd = exp_q.pop_front();
        checks += 2;
        if (bus.host_ack_o !== 1'b1) begin failures++; $display("FAIL reset_fresh_ack: got=%b expected=1", bus.host_ack_o); end
        if (bus.host_rdata_o !== exp_rd) begin failures++; $display("FAIL reset_fresh_rdata: got=%h expected=%h", bus.host_rdata_o, exp_rd); end
        bus.host_req_i = 1'b0;
        tick();
        bus.cpu_addr_i = 8'h30;
        exp_q.push_back(model_mem[8'h30]);
        #1;
        exp_rd = exp_q.pop_front();
        checks++;
        if (bus.cpu_rdata_o !== exp_rd) begin failures++; $display("FAIL reset_mem_kept: got=%h expected=%h", bus.cpu_rdata_o, exp_rd); end
    endtask

    task automatic test_host_write_read;
        host_txn(1'b1, 8'h10, 64'hDEADBEEF_00000001, 1, "host_write");
        host_txn(1'b0, 8'h10, 64'h0, 1, "host_read");
        host_txn(1'b1, 8'h11, 64'h5A5A_0000_FFFF_1111, 1, "host_write2");
        host_txn(1'b0, 8'h11, 64'h0, 1, "host_read2");
        check_cnt("host_cnt");
    endtask

    task automatic test_cpu_store_load;
        logic [63:0] exp_rd;
        bus.cpu_addr_i = 8'h05; bus.cpu_wdata_i = 64'h1234; bus.cpu_wen_i = 1'b1;
        exp_q.push_back(64'h1234);
        tick();
        bus.cpu_wen_i = 1'b0;
        model_mem[8'h05] = 64'h1234;
        count_store();
        exp_rd = exp_q.pop_front();
        checks++;
        if (bus.cpu_rdata_o !== exp_rd) begin failures++; $display("FAIL cpu_load: got=%h expected=%h", bus.cpu_rdata_o, exp_rd); end
        check_cnt("cpu_store_cnt");
    endtask

    task automatic test_conflict;
        logic [63:0] exp_rd;
        bus.cpu_addr_i = 8'h05; bus.cpu_wdata_i = 64'h5555; bus.cpu_wen_i = 1'b1;
        fork
            host_txn(1'b1, 8'h05, 64'hAAAA, 4, "conflict");
            begin
                for (int i = 0; i < 3; i++) begin
                    tick();
                    model_mem[8'h05] = 64'h5555;
                    count_store();
                end
                bus.cpu_wen_i = 1'b0;
            end
        join
        exp_q.push_back(model_mem[8'h05]);
        #1;
        exp_rd = exp_q.pop_front();
        checks += 2;
        if (bus.cpu_rdata_o !== exp_rd) begin failures++; $display("FAIL conflict_mem: got=%h expected=%h", bus.cpu_rdata_o, exp_rd); end
        if (bus.cpu_rdata_o !== 64'hAAAA) begin failures++; $display("FAIL conflict_final: got=%h expected=aaaa", bus.cpu_rdata_o); end
        check_cnt("conflict_cnt");
    endtask

    task automatic test_hold;
        logic [63:0] exp_rd;
        host_txn(1'b1, 8'h07, 64'h11, 1, "hold_prewrite");
        bus.cpu_hold_i = 1'b1;
        bus.cpu_addr_i = 8'h07; bus.cpu_wdata_i = 64'hFF; bus.cpu_wen_i = 1'b1;
        host_txn(1'b0, 8'h07, 64'h0, 1, "hold_grant");
        bus.cpu_wen_i = 1'b0;
        bus.cpu_hold_i = 1'b0;
        exp_q.push_back(model_mem[8'h07]);
        #1;
        exp_rd = exp_q.pop_front();
        checks++;
        if (bus.cpu_rdata_o !== exp_rd) begin failures++; $display("FAIL hold_mem: got=%h expected=%h", bus.cpu_rdata_o, exp_rd); end
        check_cnt("hold_cnt");
    endtask

    task automatic test_saturation;
        logic [63:0] exp_rd;
        logic [3:0]  sat_exp;
        for (int i = 0; i < 20; i++) begin
            bus.cpu_addr_i  = 8'h40 + 8'(i);
            bus.cpu_wdata_i = {32'hC0DE_0000, 32'($urandom)};
            bus.cpu_wen_i   = 1'b1;
            tick();
            model_mem[8'h40 + 8'(i)] = bus.cpu_wdata_i;
            count_store();
        end
        bus.cpu_wen_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.cpu_addr_i = 8'h40 + 8'(i);
            exp_q.push_back(model_mem[8'h40 + 8'(i)]);
            #1;
            exp_rd = exp_q.pop_front();
            checks++;
            if (bus.cpu_rdata_o !== exp_rd) begin
                failures++;
                $display("FAIL sat_mem[%0d]: got=%h expected=%h", i, bus.cpu_rdata_o, exp_rd);
            end
        end
`ifdef DMEM_WCNT_EN
        sat_exp = 4'hF;
`else
        sat_exp = 4'h0;
`endif
        checks++;
        if (bus.cpu_wr_cnt_o !== sat_exp) begin
            failures++;
            $display("FAIL sat_cnt: got=%h expected=%h", bus.cpu_wr_cnt_o, sat_exp);
        end
        check_cnt("sat_model_cnt");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 4'h0;
        bus.cpu_addr_i   = '0;
        bus.cpu_wdata_i  = '0;
        bus.cpu_wen_i    = 1'b0;
        bus.cpu_hold_i   = 1'b0;
        bus.host_req_i   = 1'b0;
        bus.host_wen_i   = 1'b0;
        bus.host_addr_i  = '0;
        bus.host_wdata_i = '0;
        for (int i = 0; i < 256; i++) model_mem[i] = 'x;

        test_reset();
        test_host_write_read();
        test_cpu_store_load();
        test_conflict();
        test_hold();
        test_saturation();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller on the downstream side of the pipeline CPU's MEM stage. It owns the data-memory array and serves two masters. The CPU port uses asynchronous read and synchronous write, so read data is valid in the same cycle as the address and can be captured by MEM/WB. The host port uses a four-phase req/ack handshake so test software can preload and inspect memory, with arbitration against CPU writes.

## Interface
Parameters:
- DATA_WIDTH, 64, word width of the memory and of both data ports
- ADDR_WIDTH, 8, word address width; depth = 2**ADDR_WIDTH
- CNT_WIDTH, 16, width of the CPU write counter

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_addr_i  in  ADDR_WIDTH  CPU MEM-stage word address
- cpu_wdata_i  in  DATA_WIDTH  CPU store data
- cpu_wen_i  in  1  CPU store enable
- cpu_hold_i  in  1  CPU held by host; when 1, CPU stores are ignored
- cpu_rdata_o  out  DATA_WIDTH  mem[cpu_addr_i], combinational
- host_req_i  in  1  host request, held until ack is seen
- host_wen_i  in  1  1 = write, 0 = read; sampled with req in IDLE
- host_addr_i  in  ADDR_WIDTH  host word address
- host_wdata_i  in  DATA_WIDTH  host write data
- host_ack_o  out  1  host acknowledge, registered
- host_rdata_o  out  DATA_WIDTH  captured read data, registered, held until next host read
- cpu_wr_cnt_o  out  CNT_WIDTH  saturating count of committed CPU stores

## Operation
- cpu_we_eff = cpu_wen_i & ~cpu_hold_i. When it is 1, mem[cpu_addr_i] <= cpu_wdata_i at the clock edge.
- cpu_rdata_o always shows current array contents. A store becomes visible the cycle after its edge; there is no same-cycle bypass.
- Host FSM has two states, IDLE and ACK. The reset state is IDLE.
- IDLE: when host_req_i & ~cpu_we_eff:
  - host_wen_i = 1: mem[host_addr_i] <= host_wdata_i.
  - host_wen_i = 0: host_rdata_o <= mem[host_addr_i].
  - Next state is ACK.
- IDLE while host_req_i & cpu_we_eff: the host waits. The CPU store wins and no host access happens that cycle.
- ACK: host_ack_o = 1. Stay in ACK while host_req_i = 1. When host_req_i = 0, go to IDLE and deassert ack. Exactly one access is performed per request.
- The array is written at most once per edge: either a CPU store or a host write, never both.
- host_rdata_o is unchanged by host writes and by CPU activity.
- Memory array contents are not reset.

## Timing
- Reset values: host_ack_o = 0, host_rdata_o = 0, cpu_wr_cnt_o = 0, FSM = IDLE. cpu_rdata_o follows the array with no reset value.
- CPU read latency is 0 cycles (combinational). CPU write latency is 1 edge.
- Host latency: req sampled high in IDLE with no CPU store at edge N. Access happens at N, ack is high after N, and host_rdata_o is valid when ack rises.
- Each cycle of CPU-store conflict delays the host by exactly one cycle. There is no starvation bound; software asserts cpu_hold_i for guaranteed access.
- Minimum handshake is 3 cycles: req up; ack up; req down then ack down on the next edge.
- Reset mid-handshake: ack drops immediately (asynchronously) and the FSM returns to IDLE. A write committed before reset stays committed. A host still holding req after reset gets a fresh access.
- Address equality between CPU and host is irrelevant because accesses never share an edge.

## Configuration
- DMEM_WCNT_EN defined: cpu_wr_cnt_o increments by 1 on every edge where cpu_we_eff = 1 and saturates at all-ones. It is cleared only by reset.
- Not defined: the counter logic is absent and cpu_wr_cnt_o is tied to 0.

## Test plan
- Reset: assert rst_n = 0 mid-simulation during ACK -> host_ack_o, host_rdata_o and cpu_wr_cnt_o are 0 immediately; FSM is IDLE after release.
- Host write then read: write 0xDEADBEEF_00000001 to address 0x10, complete the handshake, then read 0x10 -> host_rdata_o = 0xDEADBEEF_00000001 and ack is high exactly 1 cycle after each req is sampled.
- CPU store/load: cpu_wen_i = 1, address 0x05, data 0x1234 for 1 cycle -> next cycle cpu_rdata_o at address 0x05 = 0x1234; with DMEM_WCNT_EN, cpu_wr_cnt_o = 1.
- Conflict: host write to 0x05 (value 0xAAAA) while the CPU stores 0x5555 to 0x05 for 3 consecutive cycles -> ack is delayed 3 cycles and the final mem[0x05] = 0xAAAA.
- Hold: cpu_hold_i = 1 with cpu_wen_i = 1 to 0x07 (value 0xFF) -> mem[0x07] is unchanged, the counter is unchanged and the host is granted immediately.
- Saturation (DMEM_WCNT_EN, CNT_WIDTH = 4): 20 CPU stores -> cpu_wr_cnt_o = 4'hF. Without the macro, cpu_wr_cnt_o = 0 throughout.
